// File: rtl/riscv_formal_retire_seq_checker.sv
// Sequential RVFI retirement checker. It tracks a shadow register file, PC
// continuity and retirement order across NRET channels, and raises sticky error flags.
module riscv_formal_retire_seq_checker #(
  parameter int XLEN    = 32,
  parameter int NRET    = 1,
  parameter int ORDER_W = 64,
  parameter int CNT_W   = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NRET-1:0]            rvfi_valid,
  input  logic [NRET*ORDER_W-1:0]    rvfi_order,
  input  logic [NRET*5-1:0]          rvfi_rs1,
  input  logic [NRET*5-1:0]          rvfi_rs2,
  input  logic [NRET*5-1:0]          rvfi_rd,
  input  logic [NRET*XLEN-1:0]       rvfi_pre_pc,
  input  logic [NRET*XLEN-1:0]       rvfi_post_pc,
  input  logic [NRET*XLEN-1:0]       rvfi_pre_rs1,
  input  logic [NRET*XLEN-1:0]       rvfi_pre_rs2,
  input  logic [NRET*XLEN-1:0]       rvfi_post_rd,
  output logic                       err_any,
  output logic                       err_x0,
  output logic                       err_reg,
  output logic                       err_pc,
  output logic                       err_order,
  output logic                       err_gap,
  output logic [$clog2(NRET):0]      err_chan,
  output logic [ORDER_W-1:0]         err_order_val,
  output logic [CNT_W-1:0]           retired
);

  localparam int CHW = $clog2(NRET) + 1;
  localparam logic [CNT_W+3:0] RET_MAX = {4'b0, {CNT_W{1'b1}}};

  logic [XLEN-1:0]    shadow_q [32];
  logic [XLEN-1:0]    shadow_d [32];
  logic [31:0]        known_q, known_d;
  logic [XLEN-1:0]    exp_pc_q, exp_pc_d;
  logic               pc_known_q, pc_known_d;
  logic [ORDER_W-1:0] exp_order_q, exp_order_d;
  logic               order_known_q, order_known_d;
  logic [CNT_W-1:0]   retired_q, retired_d;

  logic               err_x0_q, err_reg_q, err_pc_q, err_order_q, err_gap_q;
  logic [CHW-1:0]     err_chan_q;
  logic [ORDER_W-1:0] err_order_val_q;

  logic               ev_x0, ev_reg, ev_pc, ev_order, ev_gap, ev_hit;
  logic [CHW-1:0]     ev_chan;
  logic [ORDER_W-1:0] ev_order_val;
  logic [3:0]         n_valid;
  logic [CNT_W+3:0]   ret_sum;

  // Channels are walked as a little program: each one sees the state left
  // behind by the valid channels below it.
  always_comb begin
    logic               hole;
    logic [4:0]         rs1, rs2, rd;
    logic [XLEN-1:0]    pre_pc, post_pc, val1, val2, wdata;
    logic [ORDER_W-1:0] ord;
    logic               x0_h, reg_h, pc_h, ord_h, gap_h;

    // NOTE: every always_comb target gets a default first so no path leaves it unassigned (no latch).
    shadow_d      = shadow_q;
    known_d       = known_q;
    exp_pc_d      = exp_pc_q;
    pc_known_d    = pc_known_q;
    exp_order_d   = exp_order_q;
    order_known_d = order_known_q;
    ev_x0         = 1'b0;
    ev_reg        = 1'b0;
    ev_pc         = 1'b0;
    ev_order      = 1'b0;
    ev_gap        = 1'b0;
    ev_hit        = 1'b0;
    ev_chan       = '0;
    ev_order_val  = '0;
    n_valid       = '0;
    hole          = 1'b0;
    rs1 = '0; rs2 = '0; rd = '0;
    pre_pc = '0; post_pc = '0; val1 = '0; val2 = '0; wdata = '0; ord = '0;
    x0_h = 1'b0; reg_h = 1'b0; pc_h = 1'b0; ord_h = 1'b0; gap_h = 1'b0;

    for (int i = 0; i < NRET; i++) begin
      rs1     = rvfi_rs1[i*5 +: 5];
      rs2     = rvfi_rs2[i*5 +: 5];
      rd      = rvfi_rd[i*5 +: 5];
      pre_pc  = rvfi_pre_pc[i*XLEN +: XLEN];
      post_pc = rvfi_post_pc[i*XLEN +: XLEN];
      val1    = rvfi_pre_rs1[i*XLEN +: XLEN];
      val2    = rvfi_pre_rs2[i*XLEN +: XLEN];
      wdata   = rvfi_post_rd[i*XLEN +: XLEN];
      ord     = rvfi_order[i*ORDER_W +: ORDER_W];
      x0_h = 1'b0; reg_h = 1'b0; pc_h = 1'b0; ord_h = 1'b0; gap_h = 1'b0;

      if (rvfi_valid[i]) begin
        gap_h = hole;
        if (rs1 == 5'd0) x0_h = x0_h | (val1 != '0);
        else reg_h = reg_h | (known_d[rs1] && (val1 != shadow_d[rs1]));
        if (rs2 == 5'd0) x0_h = x0_h | (val2 != '0);
        else reg_h = reg_h | (known_d[rs2] && (val2 != shadow_d[rs2]));

        // Reads above use the pre-write value, so rs == rd sees the old register.
        if (rd == 5'd0) begin
          x0_h = x0_h | (wdata != '0);
        end else begin
          shadow_d[rd] = wdata;
          known_d[rd]  = 1'b1;
        end

        pc_h          = pc_known_d && (pre_pc != exp_pc_d);
        exp_pc_d      = post_pc;
        pc_known_d    = 1'b1;
        ord_h         = order_known_d && (ord != exp_order_d);
        exp_order_d   = ord + 1'b1;
        order_known_d = 1'b1;

        ev_x0    = ev_x0 | x0_h;
        ev_reg   = ev_reg | reg_h;
        ev_pc    = ev_pc | pc_h;
        ev_order = ev_order | ord_h;
        ev_gap   = ev_gap | gap_h;
        if ((x0_h | reg_h | pc_h | ord_h | gap_h) && !ev_hit) begin
          ev_hit       = 1'b1;
          ev_chan      = CHW'(i);
          ev_order_val = ord;
        end
        n_valid = n_valid + 4'd1;
      end else begin
        hole = 1'b1;
      end
    end

    ret_sum   = {4'b0, retired_q} + (CNT_W+4)'(n_valid);
    retired_d = (ret_sum > RET_MAX) ? {CNT_W{1'b1}} : ret_sum[CNT_W-1:0];
  end

  // NOTE: the shadow file carries no reset; the known bits gate every compare,
  // so stale contents are never observed and the array stays plain storage.
  always_ff @(posedge clk) begin
    shadow_q <= shadow_d;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
      known_q         <= '0;
      exp_pc_q        <= '0;
      pc_known_q      <= 1'b0;
      exp_order_q     <= '0;
      order_known_q   <= 1'b0;
      retired_q       <= '0;
      err_x0_q        <= 1'b0;
      err_reg_q       <= 1'b0;
      err_pc_q        <= 1'b0;
      err_order_q     <= 1'b0;
      err_gap_q       <= 1'b0;
      err_chan_q      <= '0;
      err_order_val_q <= '0;
    end else begin
      known_q       <= known_d;
      exp_pc_q      <= exp_pc_d;
      pc_known_q    <= pc_known_d;
      exp_order_q   <= exp_order_d;
      order_known_q <= order_known_d;
      retired_q     <= retired_d;
      err_x0_q      <= err_x0_q | ev_x0;
      err_reg_q     <= err_reg_q | ev_reg;
      err_pc_q      <= err_pc_q | ev_pc;
      err_order_q   <= err_order_q | ev_order;
      err_gap_q     <= err_gap_q | ev_gap;
      // Only the very first error event is recorded; later ones leave it frozen.
      if (ev_hit && !err_any) begin
        err_chan_q      <= ev_chan;
        err_order_val_q <= ev_order_val;
      end
    end
  end

  assign err_x0        = err_x0_q;
  assign err_reg       = err_reg_q;
  assign err_pc        = err_pc_q;
  assign err_order     = err_order_q;
  assign err_gap       = err_gap_q;
  assign err_any       = err_x0_q | err_reg_q | err_pc_q | err_order_q | err_gap_q;
  assign err_chan      = err_chan_q;
  assign err_order_val = err_order_val_q;
  assign retired       = retired_q;

endmodule

// File: tb/tb_riscv_formal_retire_seq_checker.sv
// Bench for riscv_formal_retire_seq_checker: directed scenarios plus random
// programs with injected faults, checked against an instruction-level model.
module tb_riscv_formal_retire_seq_checker;

  localparam int NR = 2;

  typedef struct packed {
    logic        v;
    logic [63:0] ord;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] pre_pc, post_pc, a, b, wd;
  } insn_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    valid;
  logic [127:0]  order;
  logic [9:0]    rs1, rs2, rd;
  logic [63:0]   pre_pc, post_pc, pre_rs1, pre_rs2, post_rd;

  logic          err_any, err_x0, err_reg, err_pc, err_order, err_gap;
  logic [1:0]    err_chan;
  logic [63:0]   err_order_val;
  logic [31:0]   retired;
  logic          s_any, s_x0, s_reg, s_pc, s_order, s_gap;
  logic [1:0]    s_chan;
  logic [63:0]   s_order_val;
  logic [3:0]    s_retired;

  always #5 clk = ~clk;

  riscv_formal_retire_seq_checker #(.XLEN(32), .NRET(NR), .ORDER_W(64), .CNT_W(32)) u_dut (
    .clk(clk), .reset(reset), .rvfi_valid(valid), .rvfi_order(order),
    .rvfi_rs1(rs1), .rvfi_rs2(rs2), .rvfi_rd(rd),
    .rvfi_pre_pc(pre_pc), .rvfi_post_pc(post_pc),
    .rvfi_pre_rs1(pre_rs1), .rvfi_pre_rs2(pre_rs2), .rvfi_post_rd(post_rd),
    .err_any(err_any), .err_x0(err_x0), .err_reg(err_reg), .err_pc(err_pc),
    .err_order(err_order), .err_gap(err_gap), .err_chan(err_chan),
    .err_order_val(err_order_val), .retired(retired)
  );

  riscv_formal_retire_seq_checker #(.XLEN(32), .NRET(NR), .ORDER_W(64), .CNT_W(4)) u_sat (
    .clk(clk), .reset(reset), .rvfi_valid(valid), .rvfi_order(order),
    .rvfi_rs1(rs1), .rvfi_rs2(rs2), .rvfi_rd(rd),
    .rvfi_pre_pc(pre_pc), .rvfi_post_pc(post_pc),
    .rvfi_pre_rs1(pre_rs1), .rvfi_pre_rs2(pre_rs2), .rvfi_post_rd(post_rd),
    .err_any(s_any), .err_x0(s_x0), .err_reg(s_reg), .err_pc(s_pc),
    .err_order(s_order), .err_gap(s_gap), .err_chan(s_chan),
    .err_order_val(s_order_val), .retired(s_retired)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  // Reference model: architectural view of what has been retired so far.
  insn_t       ch [NR];
  logic [31:0] m_reg [32];
  bit          m_known [32];
  logic [31:0] m_pc;
  bit          m_pc_known;
  logic [63:0] m_ord;
  bit          m_ord_known;
  bit          m_x0, m_rege, m_pce, m_orde, m_gap;
  int          m_chan;
  logic [63:0] m_oval;
  longint      m_cnt;

  task automatic model_step(input bit rst);
    bit hole, hit, e, prev_any;
    int fchan;
    logic [63:0] ford;
    if (rst) begin
      for (int r = 0; r < 32; r++) m_known[r] = 0;
      m_pc_known = 0; m_ord_known = 0; m_ord = '0; m_pc = '0;
      m_x0 = 0; m_rege = 0; m_pce = 0; m_orde = 0; m_gap = 0;
      m_chan = 0; m_oval = '0; m_cnt = 0;
    end else begin
      prev_any = m_x0 | m_rege | m_pce | m_orde | m_gap;
      hole = 0; hit = 0; fchan = 0; ford = '0;
      for (int i = 0; i < NR; i++) begin
        if (!ch[i].v) begin
          hole = 1;
        end else begin
          e = 0;
          if (hole) begin m_gap = 1; e = 1; end
          if (ch[i].rs1 == 0) begin
            if (ch[i].a != 0) begin m_x0 = 1; e = 1; end
          end else if (m_known[ch[i].rs1] && ch[i].a != m_reg[ch[i].rs1]) begin
            m_rege = 1; e = 1;
          end
          if (ch[i].rs2 == 0) begin
            if (ch[i].b != 0) begin m_x0 = 1; e = 1; end
          end else if (m_known[ch[i].rs2] && ch[i].b != m_reg[ch[i].rs2]) begin
            m_rege = 1; e = 1;
          end
          if (ch[i].rd == 0) begin
            if (ch[i].wd != 0) begin m_x0 = 1; e = 1; end
          end else begin
            m_reg[ch[i].rd] = ch[i].wd;
            m_known[ch[i].rd] = 1;
          end
          if (m_pc_known && ch[i].pre_pc != m_pc) begin m_pce = 1; e = 1; end
          m_pc = ch[i].post_pc; m_pc_known = 1;
          if (m_ord_known && ch[i].ord != m_ord) begin m_orde = 1; e = 1; end
          m_ord = ch[i].ord + 64'd1; m_ord_known = 1;
          m_cnt++;
          if (e && !hit) begin hit = 1; fchan = i; ford = ch[i].ord; end
        end
      end
      if (hit && !prev_any) begin m_chan = fchan; m_oval = ford; end
    end
  endtask

  task automatic clear_ch();
    for (int i = 0; i < NR; i++) ch[i] = '0;
  endtask

  task automatic set_insn(input int i, input logic [63:0] o, input logic [31:0] pc,
                          input logic [31:0] npc, input logic [4:0] r1, input logic [4:0] r2,
                          input logic [4:0] d, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] wd);
    ch[i].v = 1; ch[i].ord = o; ch[i].pre_pc = pc; ch[i].post_pc = npc;
    ch[i].rs1 = r1; ch[i].rs2 = r2; ch[i].rd = d;
    ch[i].a = a; ch[i].b = b; ch[i].wd = wd;
  endtask

  task automatic compare_all();
    check("err_any", err_any, m_x0 | m_rege | m_pce | m_orde | m_gap);
    check("err_x0", err_x0, m_x0);
    check("err_reg", err_reg, m_rege);
    check("err_pc", err_pc, m_pce);
    check("err_order", err_order, m_orde);
    check("err_gap", err_gap, m_gap);
    check("err_chan", err_chan, m_chan);
    check("err_order_val", err_order_val, m_oval);
    check("retired", retired, m_cnt);
    check("retired_sat", s_retired, (m_cnt > 15) ? 15 : m_cnt);
    check("sat_err_any", s_any, err_any);
  endtask

  // Drive one cycle (shortly after a rising edge), advance the model, then
  // sample 1 time unit after the next rising edge.
  task automatic step(input bit rst);
    reset = rst;
    for (int i = 0; i < NR; i++) begin
      valid[i]            = ch[i].v;
      order[i*64 +: 64]   = ch[i].ord;
      rs1[i*5 +: 5]       = ch[i].rs1;
      rs2[i*5 +: 5]       = ch[i].rs2;
      rd[i*5 +: 5]        = ch[i].rd;
      pre_pc[i*32 +: 32]  = ch[i].pre_pc;
      post_pc[i*32 +: 32] = ch[i].post_pc;
      pre_rs1[i*32 +: 32] = ch[i].a;
      pre_rs2[i*32 +: 32] = ch[i].b;
      post_rd[i*32 +: 32] = ch[i].wd;
    end
    model_step(rst);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  // Random program generator state (the "true" machine being retired).
  logic [31:0] g_reg [32];
  logic [31:0] g_pc;
  logic [63:0] g_ord;

  function automatic bit fault();
    return ($urandom_range(0, 59) == 0);
  endfunction

  task automatic gen_insn(input int i);
    logic [4:0]  r1, r2, d;
    logic [31:0] a, b, wd, pc, npc;
    logic [63:0] o;
    r1 = 5'($urandom_range(0, 7));
    r2 = 5'($urandom_range(0, 7));
    d  = 5'($urandom_range(0, 7));
    a  = g_reg[r1];
    b  = g_reg[r2];
    if (fault()) a = a ^ (32'd1 << $urandom_range(0, 31));
    if (fault()) b = b ^ (32'd1 << $urandom_range(0, 31));
    wd = $urandom;
    if (d == 0) wd = fault() ? (wd | 32'd1) : 32'd0;
    else g_reg[d] = wd;
    pc  = fault() ? (g_pc + 32'd16) : g_pc;
    npc = ($urandom_range(0, 3) == 0) ? ({$urandom} & 32'hFFFF_FFFC) : pc + 32'd4;
    g_pc = npc;
    o = fault() ? (g_ord + 64'd2) : g_ord;
    g_ord = o + 64'd1;
    set_insn(i, o, pc, npc, r1, r2, d, a, b, wd);
  endtask

  initial begin
    logic [1:0] pat;
    reset = 1'b1; valid = '0; order = '0; rs1 = '0; rs2 = '0; rd = '0;
    pre_pc = '0; post_pc = '0; pre_rs1 = '0; pre_rs2 = '0; post_rd = '0;
    for (int r = 0; r < 32; r++) g_reg[r] = '0;
    clear_ch();
    @(posedge clk); #1;

    // Reset state
    clear_ch(); step(1);
    check("rst_retired", retired, 64'd0);

    // Dependent pair, clean
    clear_ch();
    set_insn(0, 64'd0, 32'h0, 32'h4, 5'd0, 5'd0, 5'd5, 32'h0, 32'h0, 32'h11);
    set_insn(1, 64'd1, 32'h4, 32'h8, 5'd5, 5'd0, 5'd0, 32'h11, 32'h0, 32'h0);
    step(0);
    check("pair_retired", retired, 64'd2);
    check("pair_noerr", err_any, 64'd0);

    // Same pair, bad read-back on channel 1
    clear_ch(); step(1);
    set_insn(0, 64'd0, 32'h0, 32'h4, 5'd0, 5'd0, 5'd5, 32'h0, 32'h0, 32'h11);
    set_insn(1, 64'd1, 32'h4, 32'h8, 5'd5, 5'd0, 5'd0, 32'h12, 32'h0, 32'h0);
    step(0);
    check("reg_flag", err_reg, 64'd1);
    check("reg_chan", err_chan, 64'd1);
    check("reg_oval", err_order_val, 64'd1);
    clear_ch(); step(0); step(0);
    check("reg_sticky", err_reg, 64'd1);

    // PC discontinuity, then x0 read
    clear_ch(); step(1);
    set_insn(0, 64'd0, 32'h0, 32'h4, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
    step(0);
    clear_ch();
    set_insn(0, 64'd1, 32'h8, 32'hC, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
    step(0);
    check("pc_flag", err_pc, 64'd1);
    clear_ch(); step(1);
    set_insn(0, 64'd7, 32'h40, 32'h44, 5'd0, 5'd0, 5'd0, 32'h1, 32'h0, 32'h0);
    step(0);
    check("x0_flag", err_x0, 64'd1);

    // Gap in channel packing
    clear_ch(); step(1);
    set_insn(1, 64'd0, 32'h0, 32'h4, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
    step(0);
    check("gap_flag", err_gap, 64'd1);
    check("gap_chan", err_chan, 64'd1);

    // Order 0,1,3
    clear_ch(); step(1);
    for (int k = 0; k < 3; k++) begin
      clear_ch();
      set_insn(0, (k == 2) ? 64'd3 : 64'(k), 32'(4*k), 32'(4*k+4),
               5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
      step(0);
    end
    check("order_flag", err_order, 64'd1);
    check("order_val", err_order_val, 64'd3);

    // Reset mid-stream with garbage inputs, then arbitrary first insn
    clear_ch();
    set_insn(0, 64'd99, 32'h123, 32'h5, 5'd0, 5'd0, 5'd0, 32'h9, 32'h0, 32'h0);
    step(1);
    check("midrst_any", err_any, 64'd0);
    clear_ch();
    set_insn(0, 64'h1234, 32'h800, 32'h804, 5'd3, 5'd4, 5'd6, 32'hAB, 32'hCD, 32'h77);
    step(0);
    check("postrst_noerr", err_any, 64'd0);

    // Order wrap, rs==rd read of old value, same-rd write priority
    clear_ch(); step(1);
    set_insn(0, 64'hFFFF_FFFF_FFFF_FFFF, 32'h0, 32'h4, 5'd0, 5'd0, 5'd3, 32'h0, 32'h0, 32'h5);
    set_insn(1, 64'h0, 32'h4, 32'h8, 5'd3, 5'd0, 5'd3, 32'h5, 32'h0, 32'h9);
    step(0);
    clear_ch();
    set_insn(0, 64'h1, 32'h8, 32'hC, 5'd0, 5'd0, 5'd4, 32'h0, 32'h0, 32'h1);
    set_insn(1, 64'h2, 32'hC, 32'h10, 5'd3, 5'd0, 5'd4, 32'h9, 32'h0, 32'h2);
    step(0);
    clear_ch();
    set_insn(0, 64'h3, 32'h10, 32'h14, 5'd4, 5'd3, 5'd0, 32'h2, 32'h9, 32'h0);
    step(0);
    check("bypass_noerr", err_any, 64'd0);

    // Saturating counter: 18 retirements
    clear_ch(); step(1);
    for (int k = 0; k < 9; k++) begin
      clear_ch();
      set_insn(0, 64'(2*k), 32'(8*k), 32'(8*k+4), 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
      set_insn(1, 64'(2*k+1), 32'(8*k+4), 32'(8*k+8), 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
      step(0);
    end
    check("sat_hold", s_retired, 64'd15);
    check("sat_main", retired, 64'd18);

    // Randomized programs with injected faults and occasional resets
    clear_ch(); step(1);
    g_pc = $urandom; g_ord = {$urandom, $urandom};
    for (int c = 0; c < 600; c++) begin
      clear_ch();
      if ($urandom_range(0, 14) == 0) begin
        if ($urandom_range(0, 1) == 1) gen_insn(0);
        step(1);
        g_pc = $urandom;
        g_ord = ($urandom_range(0, 3) == 0) ? 64'hFFFF_FFFF_FFFF_FFFE : {$urandom, $urandom};
      end else begin
        case ($urandom_range(0, 9))
          0:       pat = 2'b00;
          1:       pat = 2'b10;
          2, 3, 4: pat = 2'b01;
          default: pat = 2'b11;
        endcase
        for (int i = 0; i < NR; i++) if (pat[i]) gen_insn(i);
        step(0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/riscv_formal_retire_seq_checker.md
Name: riscv_formal_retire_seq_checker

Overview:
Multi-channel sequential checker: consumes NRET RVFI retirement channels per cycle and checks cross-instruction consistency that per-instruction checkers cannot see: register read-back against a shadow register file, PC continuity, retirement order, and channel packing. Sits beside the per-instruction checkers in the formal/sim testbench and drives sticky error flags for assertions or bench scoreboards.

Parameters:
XLEN, 32, architectural register and PC width (32 or 64)
NRET, 1, retirement channels per cycle (1..8)
ORDER_W, 64, width of rvfi_order
CNT_W, 32, width of retired-instruction counter

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
rvfi_valid  input  NRET  per-channel retire valid
rvfi_order  input  NRET*ORDER_W  per-channel retire sequence number
rvfi_rs1  input  NRET*5  rs1 index
rvfi_rs2  input  NRET*5  rs2 index
rvfi_rd  input  NRET*5  rd index
rvfi_pre_pc  input  NRET*XLEN  PC of instruction
rvfi_post_pc  input  NRET*XLEN  next PC
rvfi_pre_rs1  input  NRET*XLEN  rs1 value read
rvfi_pre_rs2  input  NRET*XLEN  rs2 value read
rvfi_post_rd  input  NRET*XLEN  rd value written
err_any  output  1  OR of all sticky error flags
err_x0  output  1  sticky: x0 read nonzero or x0 written nonzero
err_reg  output  1  sticky: rs1/rs2 value mismatches shadow
err_pc  output  1  sticky: pre_pc differs from expected PC
err_order  output  1  sticky: rvfi_order not expected sequence
err_gap  output  1  sticky: valid channel above an invalid one
err_chan  output  $clog2(NRET)+1  lowest failing channel of first error event
err_order_val  output  ORDER_W  rvfi_order of first failing instruction
retired  output  CNT_W  count of retired instructions, saturating

Behaviour:
- Channel field i = bits [i*W +: W]. Channels within one cycle are processed as a sequential program in index order 0..NRET-1.
- State: shadow regs x1..x31 (XLEN each) with known bits; exp_pc + pc_known; exp_order + order_known; retired.
- Reset (sync, any time, mid-stream included): all outputs 0, all known bits 0, pc_known=0, order_known=0, exp_order=0. Inputs during reset cycle ignored.
- Per valid channel i, with state as updated by valid channels j<i in same cycle (combinational bypass):
  - rs1==0 and pre_rs1!=0 -> x0 error; rs1!=0 and known[rs1] and pre_rs1!=shadow[rs1] -> reg error. Same for rs2. Unknown register: no check.
  - rd==0 and post_rd!=0 -> x0 error. rd!=0 -> shadow[rd]=post_rd, known=1 after channel i's own reads (rs==rd in one insn reads old value).
  - pc_known and pre_pc!=exp_pc -> pc error. Then exp_pc=post_pc, pc_known=1.
  - order_known and order!=exp_order -> order error. Then exp_order=order+1 (mod 2^ORDER_W), order_known=1.
- Gap: valid[i]=1 with any valid[j]=0, j<i -> gap error for channel i; channel still processed.
- Two channels writing same rd in one cycle: higher index wins.
- Latency: all error flags and retired update registered, visible 1 cycle after the retiring cycle.
- Flags sticky until reset. err_chan/err_order_val capture only on the first cycle any error occurs (lowest failing channel); frozen afterwards.
- retired += popcount(valid); saturates at 2^CNT_W-1, no wrap.
- No valid channels: state unchanged, no errors.

Test Plan:
- NRET=2: cycle0 ch0 order0 pc 0x0->0x4 rd=x5 post 0x11; ch1 order1 pc 0x4->0x8 rs1=x5 pre_rs1 0x11 -> no errors, retired=2 next cycle.
- Same but ch1 pre_rs1=0x12 -> err_reg=1, err_any=1, err_chan=1, err_order_val=1 one cycle later; stays set until reset.
- ch0 pre_pc 0x8 after previous post_pc 0x4 -> err_pc=1; rs1=x0 with pre_rs1=0x1 -> err_x0=1.
- valid=2'b10 -> err_gap=1, err_chan=1; order sequence 0,1,3 -> err_order=1.
- Assert reset with flags set -> all outputs 0 next cycle; first post-reset insn at arbitrary pc/order/regs -> no error (nothing known).
- CNT_W=4, retire 17 insns -> retired holds 15.
